// File: rtl/uivbuf_sched_if.sv
// Control and status bundle between one channel's DMA pair and its frame-buffer scheduler.
// The master side drives the frame pulses and enable; the slave side returns buffer indices and counters.
interface uivbuf_sched_if #(
  parameter int CNT_W = 16
);
  logic             en_i;
  logic             wr_fs_i;
  logic             wr_fe_i;
  logic             rd_fs_i;
  logic [7:0]       wr_bufn_o;
  logic [7:0]       rd_bufn_o;
  logic             rd_valid_o;
  logic [CNT_W-1:0] drop_cnt_o;
  logic [CNT_W-1:0] rpt_cnt_o;
  logic [1:0]       state_o;

  modport master (
    output en_i, wr_fs_i, wr_fe_i, rd_fs_i,
    input  wr_bufn_o, rd_bufn_o, rd_valid_o, drop_cnt_o, rpt_cnt_o, state_o
  );

  modport slave (
    input  en_i, wr_fs_i, wr_fe_i, rd_fs_i,
    output wr_bufn_o, rd_bufn_o, rd_valid_o, drop_cnt_o, rpt_cnt_o, state_o
  );
endinterface

// File: rtl/uivbuf_sched.sv
// Frame-buffer ring scheduler: advances the write buffer on committed frames and hands
// the reader the buffer BUF_DELAY frames behind, counting dropped and repeated frames.
module uivbuf_sched #(
  parameter int BUF_DELAY = 1,
  parameter int BUF_LENTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  uivbuf_sched_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [7:0] LAST   = 8'(BUF_LENTH - 1);
  localparam logic [7:0] DELAY8 = 8'(BUF_DELAY);
  localparam logic [8:0] DELAY9 = 9'(BUF_DELAY);
  localparam logic [8:0] LENTH9 = 9'(BUF_LENTH);

  state_t           state, state_nxt;
  logic [7:0]       wr_bufn, wr_bufn_nxt;
  logic [7:0]       rd_bufn, rd_bufn_nxt;
  logic             rd_valid, rd_valid_nxt;
  logic             wr_open, wr_open_nxt;
  logic [7:0]       done_cnt, done_cnt_nxt;
  logic [CNT_W-1:0] drop_cnt, drop_cnt_nxt;
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic [8:0]       wb9;
  logic [7:0]       tgt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wr_bufn  <= '0;
      rd_bufn  <= '0;
      rd_valid <= 1'b0;
      wr_open  <= 1'b0;
      done_cnt <= '0;
      drop_cnt <= '0;
      rpt_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      wr_bufn  <= wr_bufn_nxt;
      rd_bufn  <= rd_bufn_nxt;
      rd_valid <= rd_valid_nxt;
      wr_open  <= wr_open_nxt;
      done_cnt <= done_cnt_nxt;
      drop_cnt <= drop_cnt_nxt;
      rpt_cnt  <= rpt_cnt_nxt;
    end
  end

  // Frame end is applied before frame start, so a back-to-back end+start never counts as a drop
  always_comb begin
    state_nxt    = state;
    wr_bufn_nxt  = wr_bufn;
    rd_bufn_nxt  = rd_bufn;
    rd_valid_nxt = rd_valid;
    wr_open_nxt  = wr_open;
    done_cnt_nxt = done_cnt;
    drop_cnt_nxt = drop_cnt;
    rpt_cnt_nxt  = rpt_cnt;
    wb9          = '0;
    tgt          = '0;

    if (state == IDLE || !bus.en_i) begin
      wr_bufn_nxt  = '0;
      rd_bufn_nxt  = '0;
      rd_valid_nxt = 1'b0;
      wr_open_nxt  = 1'b0;
      done_cnt_nxt = '0;
      state_nxt    = (state == IDLE && bus.en_i) ? PRIME : IDLE;
    end else begin
      if (bus.wr_fe_i && wr_open) begin
        wr_bufn_nxt = (wr_bufn == LAST) ? 8'd0 : wr_bufn + 8'd1;
        wr_open_nxt = 1'b0;
        if (done_cnt < DELAY8)
          done_cnt_nxt = done_cnt + 8'd1;
      end

      if (bus.wr_fs_i) begin
        if (wr_open_nxt) begin
          if (drop_cnt != '1)
            drop_cnt_nxt = drop_cnt + 1'b1;
        end else begin
          wr_open_nxt = 1'b1;
        end
      end

      // Reader target trails the freshly updated write buffer, wrapping around the ring
      wb9 = {1'b0, wr_bufn_nxt};
      tgt = (wb9 < DELAY9) ? 8'(LENTH9 - DELAY9 + wb9) : 8'(wb9 - DELAY9);

      if (bus.rd_fs_i) begin
        if (state == RUN) begin
          rd_bufn_nxt = tgt;
          if (tgt == rd_bufn && rpt_cnt != '1)
            rpt_cnt_nxt = rpt_cnt + 1'b1;
        end else if (done_cnt_nxt == DELAY8) begin
          rd_bufn_nxt  = tgt;
          rd_valid_nxt = 1'b1;
          state_nxt    = RUN;
        end
      end
    end
  end

  assign bus.wr_bufn_o  = wr_bufn;
  assign bus.rd_bufn_o  = rd_bufn;
  assign bus.rd_valid_o = rd_valid;
  assign bus.drop_cnt_o = drop_cnt;
  assign bus.rpt_cnt_o  = rpt_cnt;
  assign bus.state_o    = state;

endmodule

// File: doc/uivbuf_sched.md
# uivbuf_sched

Frame-buffer scheduler for one video channel's DDR triple/quad-buffer ring. Tracks which buffer the writer fills and advances it on completed frames. At each read frame start it hands the reader the buffer lying BUF_DELAY frames behind. It also holds the reader off until enough frames exist and counts dropped and repeated frames. One instance sits between each channel's write DMA and read DMA in the four-screen pipeline.

## Interface
- BUF_DELAY, 1, read lag in frames; legal range 1 <= BUF_DELAY < BUF_LENTH
- BUF_LENTH, 3, number of buffers in the ring; legal range BUF_LENTH <= 255
- CNT_W, 16, width of the drop and repeat counters
- clk_i  in  1  single clock; both write and read pulses are already synchronous to it
- rst_i  in  1  synchronous, active-high reset
- en_i  in  1  scheduler enable (level)
- wr_fs_i  in  1  write frame start (1-cycle pulse)
- wr_fe_i  in  1  write frame end / frame fully committed (1-cycle pulse)
- rd_fs_i  in  1  read frame start (1-cycle pulse)
- wr_bufn_o  out  8  buffer index the writer uses
- rd_bufn_o  out  8  buffer index the reader uses
- rd_valid_o  out  1  rd_bufn_o holds real content; reader outputs blank when 0
- drop_cnt_o  out  CNT_W  truncated write frames, saturating
- rpt_cnt_o  out  CNT_W  read frames that reused the previous buffer, saturating
- state_o  out  2  0=IDLE, 1=PRIME, 2=RUN

## Operation
- **Reset:** all outputs 0; state IDLE; internal wr_open=0, done_cnt=0.
- **IDLE:**
  - wr_bufn_o=0, rd_bufn_o=0, rd_valid_o=0, wr_open=0, done_cnt=0.
  - Counters hold.
  - en_i=1 moves to PRIME on the next edge.
- **Write tracking** (PRIME and RUN):
  - wr_fs_i with wr_open=0: sets wr_open.
  - wr_fs_i with wr_open=1: the previous frame was truncated. drop_cnt+1, wr_bufn unchanged, wr_open stays 1.
  - wr_fe_i with wr_open=1: wr_bufn = (wr_bufn+1 == BUF_LENTH) ? 0 : wr_bufn+1. wr_open clears. done_cnt increments, saturating at BUF_DELAY.
  - wr_fe_i with wr_open=0: ignored.
  - wr_fe_i and wr_fs_i in the same cycle: the end is processed first (advance), then the start opens the new frame. No drop is counted.
- **Read mapping:** on rd_fs_i the target is computed from the post-update wr_bufn:
  - if wr_bufn < BUF_DELAY: BUF_LENTH - BUF_DELAY + wr_bufn
  - otherwise: wr_bufn - BUF_DELAY
  - Arithmetic is in 9 bits; the result always lies in 0..BUF_LENTH-1.
- **PRIME:**
  - rd_fs_i with done_cnt < BUF_DELAY: ignored; rd_valid_o stays 0; no counting.
  - rd_fs_i with done_cnt == BUF_DELAY: latch the target into rd_bufn_o, set rd_valid_o=1, go to RUN.
- **RUN:**
  - Every rd_fs_i latches the target into rd_bufn_o.
  - If the target equals the current rd_bufn_o, rpt_cnt+1.
- **Disable:** en_i=0 in PRIME or RUN returns to IDLE on the next edge; IDLE outputs apply. Counters hold.
- **Counters:** cleared only by rst_i; saturate at all-ones.
- **Reset mid-frame:** rst_i overrides every event in the same cycle.

## Timing
- All outputs are registered.
- wr_bufn_o changes 1 cycle after wr_fe_i.
- rd_bufn_o, rd_valid_o and rpt_cnt_o change 1 cycle after rd_fs_i.
- drop_cnt_o changes 1 cycle after the offending wr_fs_i.
- state_o changes 1 cycle after the causing input.
- rd_fs_i in the same cycle as wr_fe_i sees the advanced wr_bufn.
- There is no backpressure. Pulses are assumed to be 1 cycle wide; a held level counts once per cycle.

## Test plan
(BUF_LENTH=3, BUF_DELAY=1 unless noted.)
- **Reset:** rst_i for 2 cycles with pulses active -> all outputs 0, state_o=0. Assert rst_i during RUN -> all outputs 0 on the next edge.
- **Prime:**
  - en_i=1, then rd_fs -> rd_valid_o=0, state_o=1.
  - Then wr_fs, wr_fe -> wr_bufn_o=1.
  - Then rd_fs -> rd_bufn_o=0, rd_valid_o=1, state_o=2.
- **Wrap:** complete 2 more frames -> wr_bufn_o 2 then 0. rd_fs at wr_bufn=0 -> rd_bufn_o=2. Repeat with BUF_LENTH=4, BUF_DELAY=2, wr_bufn=1 -> rd_bufn_o=3.
- **Truncation:** wr_fs, wr_fs, wr_fe -> drop_cnt_o=1, wr_bufn advances by exactly 1. A stray wr_fe with no open frame -> no change.
- **Repeat:** two rd_fs with no write completion between them -> rd_bufn_o unchanged, rpt_cnt_o=1.
- **Simultaneous and disable:**
  - At wr_bufn=1, wr_fe and rd_fs in the same cycle -> wr_bufn_o=2, rd_bufn_o=1.
  - Then en_i=0 -> state_o=0, rd_valid_o=0, wr_bufn_o=0, counters hold.
